// File: rtl/multicycle_ctrl.sv
// Multi-cycle LEGv8 control FSM: fetch/decode/execute/memory/writeback with req/ack memories.
// Define CTRL_PERF_EN to add the InstrCount/WaitCount performance counters.
module multicycle_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic        CLK,
   input  logic        Reset_L,
   input  logic [10:0] Opcode,
   input  logic        Zero,
   input  logic        IMemAck,
   input  logic        DMemAck,
   output logic        IMemReq,
   output logic        IRWrite,
   output logic        PCWrite,
   output logic        PCSrc,
   output logic [1:0]  SignOp,
   output logic        ALUSrc,
   output logic [1:0]  ALUOp,
   output logic        DMemRead,
   output logic        DMemWrite,
   output logic        RegWrite,
   output logic        MemToReg,
   output logic        Illegal,
   output logic        InsRetired,
   output logic [2:0]  State
`ifdef CTRL_PERF_EN
   ,
   output logic [CNT_W-1:0] InstrCount,
   output logic [CNT_W-1:0] WaitCount
`endif
);

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4
   } stateT;

   typedef enum logic [2:0] {
      CLS_NONE,
      CLS_R,
      CLS_I,
      CLS_LD,
      CLS_ST,
      CLS_CBZ,
      CLS_B
   } classT;

   stateT      state;
   stateT      nextState;
   classT      insClass;
   classT      decClass;
   logic [1:0] signOpReg;
   logic [1:0] decSignOp;

   if (CNT_W < 1) begin : gBadCntW
      $error("CNT_W must be at least 1");
   end

   always_comb begin
      decClass = CLS_NONE;
      casez (Opcode)
         11'b10001011000, 11'b11001011000,
         11'b10001010000, 11'b10101010000: decClass = CLS_R;
         11'b1001000100?, 11'b1101000100?,
         11'b1001001000?, 11'b1011001000?: decClass = CLS_I;
         11'b11111000010:                  decClass = CLS_LD;
         11'b11111000000:                  decClass = CLS_ST;
         11'b10110100???:                  decClass = CLS_CBZ;
         11'b000101?????:                  decClass = CLS_B;
         default:                          decClass = CLS_NONE;
      endcase
   end

   always_comb begin
      case (decClass)
         CLS_LD, CLS_ST: decSignOp = 2'b01;
         CLS_B:          decSignOp = 2'b10;
         CLS_CBZ:        decSignOp = 2'b11;
         default:        decSignOp = 2'b00;
      endcase
   end

   // Class and immediate select are captured once in DECODE and held to the end of the instruction.
   always_ff @(posedge CLK) begin
      if (!Reset_L) begin
         state     <= FETCH;
         insClass  <= CLS_NONE;
         signOpReg <= 2'b00;
      end else begin
         state <= nextState;
         if (state == DECODE) begin
            insClass  <= decClass;
            signOpReg <= decSignOp;
         end
      end
   end

   always_comb begin
      nextState  = state;
      IMemReq    = 1'b0;
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      PCSrc      = 1'b0;
      SignOp     = 2'b00;
      ALUSrc     = 1'b0;
      ALUOp      = 2'b00;
      DMemRead   = 1'b0;
      DMemWrite  = 1'b0;
      RegWrite   = 1'b0;
      MemToReg   = 1'b0;
      Illegal    = 1'b0;
      InsRetired = 1'b0;
      State      = state;
      case (state)
         FETCH: begin
            IMemReq = 1'b1;
            if (IMemAck) begin
               IRWrite   = 1'b1;
               PCWrite   = 1'b1;
               nextState = DECODE;
            end
         end
         DECODE: begin
            if (decClass == CLS_NONE) begin
               Illegal    = 1'b1;
               InsRetired = 1'b1;
               nextState  = FETCH;
            end else begin
               nextState = EXEC;
            end
         end
         EXEC: begin
            SignOp = signOpReg;
            case (insClass)
               CLS_R: begin
                  ALUOp     = 2'b10;
                  nextState = WB;
               end
               CLS_I: begin
                  ALUSrc    = 1'b1;
                  ALUOp     = 2'b10;
                  nextState = WB;
               end
               CLS_LD, CLS_ST: begin
                  ALUSrc    = 1'b1;
                  nextState = MEM;
               end
               CLS_CBZ: begin
                  ALUOp      = 2'b01;
                  PCSrc      = 1'b1;
                  PCWrite    = Zero;
                  InsRetired = 1'b1;
                  nextState  = FETCH;
               end
               CLS_B: begin
                  PCSrc      = 1'b1;
                  PCWrite    = 1'b1;
                  InsRetired = 1'b1;
                  nextState  = FETCH;
               end
               default: nextState = FETCH;
            endcase
         end
         MEM: begin
            SignOp = signOpReg;
            if (insClass == CLS_LD) begin
               DMemRead = 1'b1;
               if (DMemAck) nextState = WB;
            end else if (insClass == CLS_ST) begin
               DMemWrite = 1'b1;
               if (DMemAck) begin
                  InsRetired = 1'b1;
                  nextState  = FETCH;
               end
            end else begin
               nextState = FETCH;
            end
         end
         WB: begin
            SignOp     = signOpReg;
            RegWrite   = 1'b1;
            MemToReg   = (insClass == CLS_LD);
            InsRetired = 1'b1;
            nextState  = FETCH;
         end
         default: nextState = FETCH;
      endcase
      // Reset forces every strobe low immediately so a held memory request cannot linger.
      if (!Reset_L) begin
         IMemReq    = 1'b0;
         IRWrite    = 1'b0;
         PCWrite    = 1'b0;
         PCSrc      = 1'b0;
         SignOp     = 2'b00;
         ALUSrc     = 1'b0;
         ALUOp      = 2'b00;
         DMemRead   = 1'b0;
         DMemWrite  = 1'b0;
         RegWrite   = 1'b0;
         MemToReg   = 1'b0;
         Illegal    = 1'b0;
         InsRetired = 1'b0;
         State      = 3'd0;
      end
   end

`ifdef CTRL_PERF_EN
   always_ff @(posedge CLK) begin
      if (!Reset_L) begin
         InstrCount <= '0;
         WaitCount  <= '0;
      end else begin
         if (InsRetired) InstrCount <= InstrCount + 1'b1;
         if ((IMemReq && !IMemAck) || ((DMemRead || DMemWrite) && !DMemAck))
            WaitCount <= WaitCount + 1'b1;
      end
   end
`endif

endmodule
